// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline sequencer (stall/flush/bubble, EX forwarding selects, ECALL drain-and-halt).
// Define HAZARD_FORWARD_EN to enable forwarding; without it every in-flight RAW dependence stalls.
module hazard_ctrl (
   input  logic       clock,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic [4:0] id_rd,
   input  logic       id_write_back,
   input  logic       id_is_load,
   input  logic       id_is_ecall,
   input  logic       ex_brk_tkn,
   output logic       pc_stall,
   output logic       fd_stall,
   output logic       fd_flush,
   output logic       de_bubble,
   output logic [1:0] fwd_a_sel,
   output logic [1:0] fwd_b_sel,
   output logic       halt
);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_cnt;
   logic [1:0] w_cnt_next;
   logic       r_halt;

   // Tracker slots: 0 = EX, 1 = MEM, 2 = WB. Only the EX slot's load bit is ever consulted.
   logic [2:0] r_trk_valid;
   logic [2:0] r_trk_wb;
   logic [4:0] r_trk_rd [3];
   logic       r_ex_load;

   logic [2:0] w_match_a;
   logic [2:0] w_match_b;
   logic       w_load_use;
   logic       w_hazard;
   logic       w_issue;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_match
         assign w_match_a[gi] = id_rs1_used && (id_rs1 != 5'd0) && r_trk_valid[gi] &&
                                r_trk_wb[gi] && (r_trk_rd[gi] == id_rs1);
         assign w_match_b[gi] = id_rs2_used && (id_rs2 != 5'd0) && r_trk_valid[gi] &&
                                r_trk_wb[gi] && (r_trk_rd[gi] == id_rs2);
      end
   endgenerate

   assign w_load_use = r_ex_load && (w_match_a[0] || w_match_b[0]);

`ifdef HAZARD_FORWARD_EN
   assign w_hazard = id_valid && w_load_use;
`else
   assign w_hazard = id_valid && (w_load_use || (|w_match_a) || (|w_match_b));
`endif

   assign w_issue = (r_state == RUN) && id_valid && !ex_brk_tkn && !w_hazard;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_trk_valid <= 3'b000;
         r_trk_wb    <= 3'b000;
         r_ex_load   <= 1'b0;
      end else begin
         r_trk_valid <= {r_trk_valid[1:0], w_issue};
         r_trk_wb    <= {r_trk_wb[1:0], w_issue && id_write_back};
         r_ex_load   <= w_issue && id_is_load;
      end
   end

   // rd needs no reset: it is always qualified by the slot's valid bit.
   always_ff @(posedge clock) begin
      r_trk_rd[0] <= id_rd;
      for (int i = 1; i < 3; i++) begin
         r_trk_rd[i] <= r_trk_rd[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= RUN;
         r_cnt   <= 2'd0;
         r_halt  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_halt  <= (w_state_next == HALT);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         RUN: begin
            if (w_issue && id_is_ecall) begin
               w_state_next = DRAIN;
               w_cnt_next   = 2'd2;
            end
         end
         DRAIN: begin
            if (r_cnt == 2'd0) begin
               w_state_next = HALT;
            end else begin
               w_cnt_next = r_cnt - 2'd1;
            end
         end
         HALT:    w_state_next = HALT;
         default: w_state_next = RUN;
      endcase
   end

   always_comb begin
      pc_stall  = 1'b0;
      fd_stall  = 1'b0;
      fd_flush  = 1'b0;
      de_bubble = 1'b0;
      unique case (r_state)
         HALT: begin
            pc_stall  = 1'b1;
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
         end
         DRAIN: begin
            pc_stall = 1'b1;
            fd_flush = 1'b1;
         end
         default: begin
            if (ex_brk_tkn) begin
               fd_flush  = 1'b1;
               de_bubble = 1'b1;
            end else if (w_hazard) begin
               pc_stall  = 1'b1;
               fd_stall  = 1'b1;
               de_bubble = 1'b1;
            end
         end
      endcase
   end

   assign halt = r_halt;

`ifdef HAZARD_FORWARD_EN
   logic [1:0] r_fwd_a;
   logic [1:0] r_fwd_b;
   logic [1:0] w_sel_a;
   logic [1:0] w_sel_b;

   // EX-slot producer will sit in MEM next cycle, so it takes priority over the WB value.
   assign w_sel_a = w_match_a[0] ? 2'd1 : (w_match_a[1] ? 2'd2 : 2'd0);
   assign w_sel_b = w_match_b[0] ? 2'd1 : (w_match_b[1] ? 2'd2 : 2'd0);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fwd_a <= 2'd0;
         r_fwd_b <= 2'd0;
      end else begin
         r_fwd_a <= w_issue ? w_sel_a : 2'd0;
         r_fwd_b <= w_issue ? w_sel_b : 2'd0;
      end
   end

   assign fwd_a_sel = r_fwd_a;
   assign fwd_b_sel = r_fwd_b;
`else
   assign fwd_a_sel = 2'd0;
   assign fwd_b_sel = 2'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       wb;
      logic       ld;
      logic       ec;
   } instr_t;

`ifdef HAZARD_FORWARD_EN
   localparam int       N_ALU1  = 0;
   localparam int       N_GAP   = 0;
   localparam int       N_LU    = 1;
   localparam logic [3:0] FWD_ALU1 = 4'b0100;
   localparam logic [3:0] FWD_GAP  = 4'b1000;
   localparam logic [3:0] FWD_LU   = 4'b1010;
   localparam logic [3:0] FWD_B2B  = 4'b1000;
`else
   localparam int       N_ALU1  = 3;
   localparam int       N_GAP   = 2;
   localparam int       N_LU    = 3;
   localparam logic [3:0] FWD_ALU1 = 4'b0000;
   localparam logic [3:0] FWD_GAP  = 4'b0000;
   localparam logic [3:0] FWD_LU   = 4'b0000;
   localparam logic [3:0] FWD_B2B  = 4'b0000;
`endif

   localparam logic [3:0] IDLE  = 4'b0000;  // {pc_stall, fd_stall, fd_flush, de_bubble}
   localparam logic [3:0] STALL = 4'b1101;
   localparam logic [3:0] FLUSH = 4'b0011;
   localparam logic [3:0] HALTC = 4'b1011;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1 = 5'd0;
   logic [4:0] id_rs2 = 5'd0;
   logic       id_rs1_used = 1'b0;
   logic       id_rs2_used = 1'b0;
   logic [4:0] id_rd = 5'd0;
   logic       id_write_back = 1'b0;
   logic       id_is_load = 1'b0;
   logic       id_is_ecall = 1'b0;
   logic       ex_brk_tkn = 1'b0;
   logic       pc_stall, fd_stall, fd_flush, de_bubble, halt;
   logic [1:0] fwd_a_sel, fwd_b_sel;

   int n_tests = 0;
   int n_fail  = 0;

   wire [3:0] ctl = {pc_stall, fd_stall, fd_flush, de_bubble};
   wire [3:0] fwd = {fwd_a_sel, fwd_b_sel};

   hazard_ctrl dut (
      .clock(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_write_back(id_write_back), .id_is_load(id_is_load),
      .id_is_ecall(id_is_ecall), .ex_brk_tkn(ex_brk_tkn),
      .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush), .de_bubble(de_bubble),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halt(halt)
   );

   always #5 clk = ~clk;

   function automatic instr_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                 input logic u2, input logic [4:0] rd, input logic wb,
                                 input logic ld, input logic ec);
      instr_t i;
      i.valid = 1'b1; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
      i.rd = rd; i.wb = wb; i.ld = ld; i.ec = ec;
      return i;
   endfunction

   instr_t NOP, ADD5, SUB6, INDEP, LW7, ADD8, LW9, ADD10, ADDI0, ADD9, ECALL, LW17, ECALL17;

   // Drive one ID-stage cycle at the falling edge, then settle before checks.
   task automatic step(input instr_t i, input logic brk);
      @(negedge clk);
      id_valid = i.valid; id_rs1 = i.rs1; id_rs1_used = i.u1; id_rs2 = i.rs2;
      id_rs2_used = i.u2; id_rd = i.rd; id_write_back = i.wb; id_is_load = i.ld;
      id_is_ecall = i.ec; ex_brk_tkn = brk;
      #1;
      $display("[TB] t=%0t v=%b rs1=%0d rs2=%0d rd=%0d brk=%b ctl=%b fwd=%b halt=%b",
               $time, i.valid, i.rs1, i.rs2, i.rd, brk, ctl, fwd, halt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      id_valid = 1'b0; id_is_ecall = 1'b0; ex_brk_tkn = 1'b0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_write_back = 1'b0; id_is_load = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, IDLE); end
      n_tests++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd got=%b exp=0000", fwd); end
      n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got=%b exp=0", halt); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_alu_fwd();
      do_reset();
      step(ADD5, 1'b0);
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL alu_add got=%b exp=%b", ctl, IDLE); end
      step(SUB6, 1'b0);
      for (int k = 0; k < N_ALU1; k++) begin
         n_tests++; if (ctl !== STALL) begin n_fail++; $display("FAIL alu_stall%0d got=%b exp=%b", k, ctl, STALL); end
         step(SUB6, 1'b0);
      end
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL alu_issue got=%b exp=%b", ctl, IDLE); end
      step(NOP, 1'b0);
      n_tests++; if (fwd !== FWD_ALU1) begin n_fail++; $display("FAIL alu_fwd got=%b exp=%b", fwd, FWD_ALU1); end
   endtask

   task automatic test_gap_fwd();
      do_reset();
      step(ADD5, 1'b0);
      step(INDEP, 1'b0);
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL gap_indep got=%b exp=%b", ctl, IDLE); end
      step(SUB6, 1'b0);
      for (int k = 0; k < N_GAP; k++) begin
         n_tests++; if (ctl !== STALL) begin n_fail++; $display("FAIL gap_stall%0d got=%b exp=%b", k, ctl, STALL); end
         step(SUB6, 1'b0);
      end
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL gap_issue got=%b exp=%b", ctl, IDLE); end
      step(NOP, 1'b0);
      n_tests++; if (fwd !== FWD_GAP) begin n_fail++; $display("FAIL gap_fwd got=%b exp=%b", fwd, FWD_GAP); end
   endtask

   task automatic test_load_use();
      do_reset();
      step(LW7, 1'b0);
      step(ADD8, 1'b0);
      for (int k = 0; k < N_LU; k++) begin
         n_tests++; if (ctl !== STALL) begin n_fail++; $display("FAIL lu_stall%0d got=%b exp=%b", k, ctl, STALL); end
         step(ADD8, 1'b0);
      end
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL lu_issue got=%b exp=%b", ctl, IDLE); end
      step(NOP, 1'b0);
      n_tests++; if (fwd !== FWD_LU) begin n_fail++; $display("FAIL lu_fwd got=%b exp=%b", fwd, FWD_LU); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(LW7, 1'b0);
      step(LW9, 1'b0);
      for (int k = 0; k < N_LU; k++) begin
         n_tests++; if (ctl !== STALL) begin n_fail++; $display("FAIL b2b_stall1_%0d got=%b exp=%b", k, ctl, STALL); end
         step(LW9, 1'b0);
      end
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL b2b_issue1 got=%b exp=%b", ctl, IDLE); end
      step(ADD10, 1'b0);
      n_tests++; if (fwd !== FWD_B2B) begin n_fail++; $display("FAIL b2b_fwd1 got=%b exp=%b", fwd, FWD_B2B); end
      for (int k = 0; k < N_LU; k++) begin
         n_tests++; if (ctl !== STALL) begin n_fail++; $display("FAIL b2b_stall2_%0d got=%b exp=%b", k, ctl, STALL); end
         step(ADD10, 1'b0);
      end
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL b2b_issue2 got=%b exp=%b", ctl, IDLE); end
      step(NOP, 1'b0);
      n_tests++; if (fwd !== FWD_B2B) begin n_fail++; $display("FAIL b2b_fwd2 got=%b exp=%b", fwd, FWD_B2B); end
   endtask

   task automatic test_x0();
      do_reset();
      step(ADDI0, 1'b0);
      step(ADD9, 1'b0);
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL x0_ctl got=%b exp=%b", ctl, IDLE); end
      step(NOP, 1'b0);
      n_tests++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL x0_fwd got=%b exp=0000", fwd); end
   endtask

   task automatic test_branch();
      do_reset();
      step(LW7, 1'b0);
      step(ADD8, 1'b1);
      n_tests++; if (ctl !== FLUSH) begin n_fail++; $display("FAIL br_flush got=%b exp=%b", ctl, FLUSH); end
      step(NOP, 1'b0);
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL br_after got=%b exp=%b", ctl, IDLE); end
      n_tests++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL br_fwd got=%b exp=0000", fwd); end
      step(ECALL, 1'b1);
      n_tests++; if (ctl !== FLUSH) begin n_fail++; $display("FAIL br_ecall got=%b exp=%b", ctl, FLUSH); end
      for (int k = 0; k < 4; k++) begin
         step(NOP, 1'b0);
         n_tests++; if (ctl !== IDLE || halt !== 1'b0) begin
            n_fail++; $display("FAIL br_nodrain%0d got=%b/%b exp=%b/0", k, ctl, halt, IDLE);
         end
      end
   endtask

   task automatic test_ecall();
      do_reset();
      step(ECALL, 1'b0);
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL ec_issue got=%b exp=%b", ctl, IDLE); end
      for (int k = 0; k < 3; k++) begin
         step(NOP, 1'b0);
         n_tests++; if ({pc_stall, fd_flush, halt} !== 3'b110) begin
            n_fail++; $display("FAIL ec_drain%0d got=%b exp=110", k, {pc_stall, fd_flush, halt});
         end
      end
      step(NOP, 1'b0);
      n_tests++; if ({ctl, halt} !== {HALTC, 1'b1}) begin n_fail++; $display("FAIL ec_halt got=%b exp=%b", {ctl, halt}, {HALTC, 1'b1}); end
      step(ADD5, 1'b1);
      n_tests++; if ({ctl, halt} !== {HALTC, 1'b1}) begin n_fail++; $display("FAIL ec_hold got=%b exp=%b", {ctl, halt}, {HALTC, 1'b1}); end
      @(negedge clk); reset = 1'b1; id_valid = 1'b0; ex_brk_tkn = 1'b0;
      @(negedge clk); reset = 1'b0; #1;
      n_tests++; if ({ctl, halt} !== 5'b00000) begin n_fail++; $display("FAIL ec_rst_halt got=%b exp=00000", {ctl, halt}); end
   endtask

   task automatic test_reset_drain();
      do_reset();
      step(ECALL, 1'b0);
      step(NOP, 1'b0);
      n_tests++; if ({pc_stall, fd_flush} !== 2'b11) begin n_fail++; $display("FAIL rd_drain got=%b exp=11", {pc_stall, fd_flush}); end
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; #1;
      n_tests++; if ({ctl, halt} !== 5'b00000) begin n_fail++; $display("FAIL rd_run got=%b exp=00000", {ctl, halt}); end
      for (int k = 0; k < 4; k++) begin
         step(NOP, 1'b0);
         n_tests++; if ({ctl, halt} !== 5'b00000) begin n_fail++; $display("FAIL rd_stay%0d got=%b exp=00000", k, {ctl, halt}); end
      end
   endtask

   task automatic test_ecall_stalled();
      do_reset();
      step(LW17, 1'b0);
      step(ECALL17, 1'b0);
      for (int k = 0; k < N_LU; k++) begin
         n_tests++; if (ctl !== STALL) begin n_fail++; $display("FAIL ecs_stall%0d got=%b exp=%b", k, ctl, STALL); end
         step(ECALL17, 1'b0);
      end
      n_tests++; if (ctl !== IDLE) begin n_fail++; $display("FAIL ecs_issue got=%b exp=%b", ctl, IDLE); end
      for (int k = 0; k < 3; k++) begin
         step(NOP, 1'b0);
         n_tests++; if ({pc_stall, fd_flush, halt} !== 3'b110) begin
            n_fail++; $display("FAIL ecs_drain%0d got=%b exp=110", k, {pc_stall, fd_flush, halt});
         end
      end
      step(NOP, 1'b0);
      n_tests++; if (halt !== 1'b1) begin n_fail++; $display("FAIL ecs_halt got=%b exp=1", halt); end
   endtask

   initial begin
      NOP     = '0;
      ADD5    = mk(5'd1,  1'b1, 5'd2, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0);
      SUB6    = mk(5'd5,  1'b1, 5'd3, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0);
      INDEP   = mk(5'd11, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
      LW7     = mk(5'd1,  1'b1, 5'd0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0);
      ADD8    = mk(5'd7,  1'b1, 5'd7, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0);
      LW9     = mk(5'd7,  1'b1, 5'd0, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0);
      ADD10   = mk(5'd9,  1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
      ADDI0   = mk(5'd0,  1'b1, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0);
      ADD9    = mk(5'd0,  1'b1, 5'd0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0);
      ECALL   = mk(5'd0,  1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1);
      LW17    = mk(5'd2,  1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 1'b1, 1'b0);
      ECALL17 = mk(5'd17, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1);

      test_reset();
      test_alu_fwd();
      test_gap_fwd();
      test_load_use();
      test_back_to_back();
      test_x0();
      test_branch();
      test_ecall();
      test_reset_drain();
      test_ecall_stalled();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencer for the five-stage core. Takes per-instruction decode fields from the ID stage and the branch-taken result from EX, and drives the rest of the pipeline:
- PC stall and IF/ID stall/flush.
- ID/EX bubble insertion.
- Registered EX-operand forwarding selects.
- ECALL drain-and-halt sequence.

It keeps a three-entry in-flight tracker (EX, MEM, WB) of destination-register information.

## Interface
Parameters:
- none.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high; one clock, one reset domain.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_rs1, id_rs2  in  5 each  source registers of the ID instruction.
- id_rs1_used, id_rs2_used  in  1 each  the ID instruction reads that source.
- id_rd  in  5  destination register of the ID instruction.
- id_write_back  in  1  the ID instruction writes the register file.
- id_is_load  in  1  the ID instruction writes back from memory (write_back=1, WB_sel=0).
- id_is_ecall  in  1  the ID instruction is ECALL.
- ex_brk_tkn  in  1  taken branch or jump resolved in EX this cycle.
- pc_stall  out  1  hold the PC.
- fd_stall  out  1  hold the IF/ID register.
- fd_flush  out  1  load a NOP into IF/ID.
- de_bubble  out  1  load a NOP into ID/EX.
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 0 = register file, 1 = MEM-stage ALU result, 2 = WB-stage writeback value.
- halt  out  1  sticky; ECALL has retired.

## Operation
Tracker:
- Entries ex/mem/wb, each holding {valid, rd, wb, load}.
- Each cycle the tracker shifts ex→mem→wb.
- ex is loaded with the ID fields when an instruction issues.
- ex is loaded with an invalid entry when de_bubble=1.

Match rule:
- A source matches an entry when all of the following hold: the source is used, the entry is valid, entry.wb=1, entry.rd==src, and src≠0.
- x0 never matches.

Load-use:
- Condition: an ID source matches the ex entry and ex.load=1.
- Response: pc_stall=1, fd_stall=1, de_bubble=1 for one cycle.

Forwarding:
- Computed from the ID sources, registered, and valid in the cycle the instruction occupies EX.
- A match on the ex entry gives sel=1 (the producer will be in MEM).
- Otherwise a match on the mem entry gives sel=2.
- Otherwise sel=0.
- MEM-side priority over WB-side.
- Selects are cleared to 0 when a bubble is issued.

Branch flush:
- ex_brk_tkn=1 gives fd_flush=1 and de_bubble=1 in the same cycle.
- pc_stall=0, so the PC loads the target.
- Flush overrides load-use: stall signals are forced 0 that cycle and the ID instruction is squashed.

FSM states: RUN, DRAIN, HALT.
- RUN → DRAIN: when an ECALL issues, meaning id_is_ecall, id_valid, no stall, no flush. Counter loads 2.
- DRAIN:
  - pc_stall=1 and fd_flush=1; later fetches are discarded.
  - Counter decrements each cycle.
  - At 0 (ECALL in WB) → HALT.
- HALT: halt=1, pc_stall=1, fd_flush=1, de_bubble=1. Held until reset.
- An ECALL squashed by a flush does not enter DRAIN.
- An ECALL held by a load-use stall enters DRAIN on the cycle it actually issues.

## Timing
- Reset values:
  - state = RUN, counter = 0.
  - All tracker entries invalid.
  - fwd_a_sel = fwd_b_sel = 0, halt = 0.
  - pc_stall, fd_stall, fd_flush, de_bubble = 0, given id_valid=0 and ex_brk_tkn=0.
- pc_stall, fd_stall, fd_flush and de_bubble are combinational from the registered state plus ID/EX inputs. They have zero-cycle latency.
- fwd_*_sel and halt are registered, with one-cycle latency from ID.
- Reset mid-DRAIN or mid-HALT returns to RUN at the next edge.
- Back-to-back load-use on consecutive instructions: each gets exactly one stall cycle.
- Priority, highest first: reset > HALT/DRAIN > ex_brk_tkn > load-use > normal issue.

## Configuration
- HAZARD_FORWARD_EN defined:
  - Forwarding as described above.
  - Only load-use stalls.
- HAZARD_FORWARD_EN undefined:
  - fwd_*_sel tied to 0.
  - Any ID source matching the ex, mem or wb entry stalls: pc_stall=fd_stall=de_bubble=1.
  - The stall repeats until no match remains, at most 3 cycles.
  - Branch flush and ECALL behaviour unchanged.

## Test plan
- Forwarding, ALU-to-ALU: `add x5,x1,x2` then `sub x6,x5,x3` → no stall; fwd_a_sel=1 while sub is in EX. With one independent instruction between them → fwd_a_sel=2.
- Load-use: `lw x7,0(x1)` then `add x8,x7,x7` → exactly one cycle of pc_stall=fd_stall=de_bubble=1; add then reaches EX with fwd_a_sel=fwd_b_sel=2.
- x0 guard: `addi x0,x0,5` then `add x9,x0,x0` → no stall, selects 0.
- Branch versus stall: lw x7 in EX (ex.load=1, ex.rd=7) with ex_brk_tkn=1 and a dependent instruction in ID → fd_flush=de_bubble=1, pc_stall=0, no stall; the next cycle shows no stall.
- ECALL: ECALL issues → DRAIN for 3 cycles with pc_stall=fd_flush=1, then halt=1 held. Asserting reset in the second DRAIN cycle → RUN and halt=0 after one edge.
- Without HAZARD_FORWARD_EN: `add x5,...` then `sub x6,x5,...` → 3 stall cycles, then issue with selects 0.
